// File: rtl/delay_sched_pkg.sv
// Shared types, defaults and helpers for the delay-timer scheduler.
// States of the timer-ownership FSM and the index-to-one-hot decode.
// Imported by the scheduler top and its arbiter.
package delay_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;
  localparam int MAX_REQ   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } sched_state_t;

  // Decode a requester index into a one-hot vector wide enough for any legal N_REQ.
  function automatic logic [MAX_REQ-1:0] sched_onehot(input logic [2:0] idx);
    sched_onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, search starting at ptr and wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; en low forces no winner so requests just wait.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Scan from the farthest offset back to the pointer so the nearest request wins.
  always_comb begin
    int c;
    c   = 0;
    idx = '0;
    vld = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      if (en && req[c]) begin
        idx = IW'(c);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_timer_scheduler.sv
// Shares one delay timer among N_REQ requesters, one weighted-width pulse at a time.
// Latency: grant the cycle after a request is seen in IDLE, pulse from the cycle after that.
// Backpressure: requests are held levels; non-owners wait, owner drop during the pulse cancels it.
module delay_timer_scheduler
  import delay_sched_pkg::*;
#(
  parameter int  N_REQ    = DEF_N_REQ,
  parameter int  W        = DEF_W,
  parameter int  PRESCALE = 1,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_wb,
  output logic [N_REQ-1:0]   o_grant,
  output logic [IW-1:0]      o_owner,
  output logic               o_busy,
  output logic               o_pulse,
  output logic [N_REQ-1:0]   o_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  sched_state_t     state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic [W-1:0]     cnt;
  logic [W-1:0]     wb_sel;
  logic [IW-1:0]    win_idx;
  logic             win_vld;
  logic             pre_wrap;
  logic [N_REQ-1:0] owner_oh;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (i_req),
    .ptr (ptr),
    .en  (state == ST_IDLE),
    .idx (win_idx),
    .vld (win_vld)
  );

  assign wb_sel   = i_wb[owner*W +: W];
  assign ptr_next = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
  assign owner_oh = N_REQ'(sched_onehot(3'(owner)));

  // Prescaler only exists when a timer count spans more than one clock.
  if (PRESCALE > 1) begin : g_pre
    logic [PW-1:0] pre;

    // Count 0..PRESCALE-1 while the pulse runs; held at zero otherwise.
    always_ff @(posedge i_Clk) begin
      if (i_Rst || state != ST_RUN) pre <= '0;
      else if (pre_wrap)            pre <= '0;
      else                          pre <= pre + PW'(1);
    end

    assign pre_wrap = (pre == PW'(PRESCALE - 1));
  end else begin : g_nopre
    assign pre_wrap = 1'b1;
  end

  // Ownership FSM: arbitrate, latch width, time the pulse, then release and move the pointer.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            owner <= win_idx;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= wb_sel;
          state <= (wb_sel == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          // Expiry is checked first so it beats a simultaneous cancel.
          if (pre_wrap && cnt == W'(1)) state <= ST_DONE;
          else if (!i_req[owner])       state <= ST_CANCEL;
          else if (pre_wrap)            cnt   <= cnt - W'(1);
        end
        ST_DONE, ST_CANCEL: begin
          ptr   <= ptr_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_pulse = (state == ST_RUN);
  assign o_grant = o_busy ? owner_oh : '0;
  assign o_owner = o_busy ? owner : '0;
  assign o_done  = (state == ST_DONE) ? owner_oh : '0;

endmodule
